// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin owner of the write port of one shared register.
// Each granted requester gets one write followed by a read-back verify; a failed
// verify is retried up to MAX_RETRY times, after which the grant is returned
// with err set so the requester knows its data did not stick.
module reg_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 2,
    parameter int MAX_RETRY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  err,
    output logic                  busy,
    output logic [WIDTH-1:0]      reg_in,
    output logic                  reg_en,
    input  logic [WIDTH-1:0]      reg_out
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CHECK
    } state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_win;
    logic [WIDTH-1:0]  r_hold;
    logic [2:0]        r_retry;
    logic              r_reg_en;
    logic              r_busy;

    logic              w_any_req;
    logic              w_found;
    logic [PTR_W-1:0]  w_winner;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_match;
    logic              w_retry_done;
    logic [PTR_W-1:0]  w_ptr_next;
    logic [NREQ-1:0]   w_gnt;
    logic              w_err;

    // Modular add on requester indices; the wrap is explicit so a
    // non-power-of-2 NREQ never lands on an unused index.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return PTR_W'(sum);
    endfunction

    // Pick the first requester at or after r_ptr and mux out its data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_any_req  = |req;
        w_found    = 1'b0;
        w_winner   = '0;
        w_sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[wrap_add(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = wrap_add(r_ptr, k);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == PTR_W'(i)) w_sel_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign w_match      = (reg_out == r_hold);
    assign w_retry_done = (r_retry == 3'(MAX_RETRY));
    assign w_ptr_next   = wrap_add(r_win, 1);

    // Arbitration / write / verify sequencer with registered reg_en and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_hold   <= '0;
            r_retry  <= '0;
            r_reg_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_hold   <= w_sel_data;
                        r_win    <= w_winner;
                        r_retry  <= '0;
                        r_state  <= S_WRITE;
                        r_reg_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state  <= S_CHECK;
                    r_reg_en <= 1'b0;
                end
                S_CHECK: begin
                    if (w_match || w_retry_done) begin
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_retry  <= r_retry + 3'd1;
                        r_state  <= S_WRITE;
                        r_reg_en <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_reg_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulse in the CHECK cycle; masked while reset is cancelling the operation.
    always_comb begin
        w_gnt = '0;
        w_err = 1'b0;
        if (!reset && (r_state == S_CHECK) && (w_match || w_retry_done)) begin
            w_gnt[r_win] = 1'b1;
            w_err        = !w_match;
        end
    end

    assign gnt    = w_gnt;
    assign err    = w_err;
    assign busy   = r_busy;
    assign reg_en = r_reg_en;
    assign reg_in = r_hold;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NREQ=3, WIDTH=8, MAX_RETRY=2) with a
// behavioural register model and a scoreboard of expected writes and grants.
module tb_reg_write_arbiter;

    localparam int WIDTH     = 8;
    localparam int NREQ      = 3;
    localparam int MAX_RETRY = 2;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            err;
    } gnt_exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  err;
    logic                  busy;
    logic [WIDTH-1:0]      reg_in;
    logic                  reg_en;
    logic [WIDTH-1:0]      reg_out;

    int n_chk = 0;
    int n_err = 0;
    int n_en  = 0;

    logic [WIDTH-1:0] exp_wr[$];
    gnt_exp_t         exp_gnt[$];

    // Register model: written on posedge when reg_en, read combinationally.
    // A number of read-backs can be forced to 00 to provoke verify failures.
    logic [WIDTH-1:0] reg_q = '0;
    logic             rb = 1'b0;
    int               rb_total = 0;
    int               corrupt_base = 0;
    int               corrupt_n = 0;

    assign reg_out = ((rb_total - corrupt_base) < corrupt_n) ? '0 : reg_q;

    always @(posedge clk) begin
        if (reg_en) reg_q <= reg_in;
        rb <= reg_en;
        if (rb) rb_total <= rb_total + 1;
    end

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .err(err), .busy(busy), .reg_in(reg_in),
        .reg_en(reg_en), .reg_out(reg_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_wr(input logic [WIDTH-1:0] d);
        exp_wr.push_back(d);
    endtask

    task automatic push_gnt(input logic [NREQ-1:0] g, input logic e);
        gnt_exp_t t;
        t.gnt = g;
        t.err = e;
        exp_gnt.push_back(t);
    endtask

    // Wait (bounded) for a grant; checks it arrived and after how many negedges.
    task automatic wait_gnt(input string tag, input int max_cyc, input int exp_lat);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < max_cyc) begin
            tick();
            n++;
            if (gnt != '0) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    // Scoreboard monitor: every write and every grant is matched against the queues.
    always @(negedge clk) begin
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("err_without_gnt", 32'(err && (gnt == '0)), 32'd0);
        if (reg_en) begin
            n_en++;
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) check("wr_data", 32'(reg_in), 32'(exp_wr.pop_front()));
        end
        if (gnt != '0) begin
            check("gnt_expected", 32'(exp_gnt.size() != 0), 32'd1);
            if (exp_gnt.size() != 0) begin
                gnt_exp_t t;
                t = exp_gnt.pop_front();
                check("gnt_vec", 32'(gnt), 32'(t.gnt));
                check("gnt_err", 32'(err), 32'(t.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0;
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (2) tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reg_en", 32'(reg_en), 32'd0);
        check("rst_reg_in", 32'(reg_in), 32'd0);
        reset = 1'b0;
        tick();

        // Single write from requester 0.
        en0 = n_en;
        req_data[7:0] = 8'hA5;
        req = 3'b001;
        push_wr(8'hA5);
        push_gnt(3'b001, 1'b0);
        tick();
        check("single_reg_en", 32'(reg_en), 32'd1);
        check("single_reg_in", 32'(reg_in), 32'hA5);
        check("single_busy", 32'(busy), 32'd1);
        wait_gnt("single", 10, 1);
        check("single_err", 32'(err), 32'd0);
        req[0] = 1'b0;
        tick();
        check("single_en_cnt", 32'(n_en - en0), 32'd1);
        check("single_idle", 32'(busy), 32'd0);

        // One failed read-back, then success (requester 1, ptr now 1).
        en0 = n_en;
        corrupt_base = rb_total;
        corrupt_n = 1;
        req_data[15:8] = 8'h3C;
        req = 3'b010;
        push_wr(8'h3C);
        push_wr(8'h3C);
        push_gnt(3'b010, 1'b0);
        wait_gnt("retry1", 12, 4);
        check("retry1_err", 32'(err), 32'd0);
        req[1] = 1'b0;
        tick();
        check("retry1_en_cnt", 32'(n_en - en0), 32'd2);

        // Every read-back fails: abort with err after MAX_RETRY retries (requester 2).
        en0 = n_en;
        corrupt_base = rb_total;
        corrupt_n = 3;
        req_data[23:16] = 8'h5A;
        req = 3'b100;
        repeat (3) push_wr(8'h5A);
        push_gnt(3'b100, 1'b1);
        wait_gnt("abort", 16, 6);
        check("abort_err", 32'(err), 32'd1);
        req[2] = 1'b0;
        tick();
        corrupt_n = 0;
        check("abort_en_cnt", 32'(n_en - en0), 32'd3);

        // Data changed during WRITE must not affect the captured value (ptr wrapped to 0).
        req_data[7:0] = 8'h77;
        req = 3'b001;
        push_wr(8'h77);
        push_gnt(3'b001, 1'b0);
        tick();
        check("cap_reg_en", 32'(reg_en), 32'd1);
        req_data[7:0] = 8'hFF;
        #1;
        check("cap_reg_in", 32'(reg_in), 32'h77);
        wait_gnt("cap", 10, 1);
        req[0] = 1'b0;
        tick();

        // Reset during WRITE of requester 1 (ptr=1); afterwards ptr=0 so requester 0 wins first.
        req_data[15:8] = 8'h99;
        req = 3'b010;
        push_wr(8'h99);
        tick();
        check("rstmid_reg_en", 32'(reg_en), 32'd1);
        req_data[7:0] = 8'h44;
        req[0] = 1'b1;
        reset = 1'b1;
        push_wr(8'h44);
        push_wr(8'h99);
        push_gnt(3'b001, 1'b0);
        push_gnt(3'b010, 1'b0);
        tick();
        check("rstmid_reg_en_off", 32'(reg_en), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_gnt", 32'(gnt), 32'd0);
        reset = 1'b0;
        wait_gnt("rstmid_g0", 10, 2);
        req[0] = 1'b0;
        wait_gnt("rstmid_g1", 10, 3);
        req[1] = 1'b0;
        tick();

        // Round robin from reset: all high, each drops on its own grant.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_data = {8'h33, 8'h22, 8'h11};
        req = 3'b111;
        push_wr(8'h11); push_wr(8'h22); push_wr(8'h33);
        push_gnt(3'b001, 1'b0); push_gnt(3'b010, 1'b0); push_gnt(3'b100, 1'b0);
        wait_gnt("rr0", 10, 2);
        req[0] = 1'b0;
        wait_gnt("rr1", 10, 3);
        req[1] = 1'b0;
        wait_gnt("rr2", 10, 3);
        req[2] = 1'b0;
        tick();

        // Fairness wrap: move ptr to 1, then hold req2 and req0 high together.
        req_data = {8'h2C, 8'h00, 8'h0A};
        req = 3'b001;
        push_wr(8'h0A);
        push_gnt(3'b001, 1'b0);
        wait_gnt("fw_pre", 10, 2);
        req[0] = 1'b0;
        tick();
        req = 3'b101;
        for (int i = 0; i < 2; i++) begin
            push_wr(8'h2C); push_gnt(3'b100, 1'b0);
            push_wr(8'h0A); push_gnt(3'b001, 1'b0);
        end
        wait_gnt("fw0", 10, 2);
        wait_gnt("fw1", 10, 3);
        wait_gnt("fw2", 10, 3);
        wait_gnt("fw3", 10, 3);
        req = '0;
        repeat (3) tick();

        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
